wb_sequencer: RTL and testbench
===============================

Name: wb_sequencer

Overview:
Sequences the register-file writeback stage. Accepts one completed instruction at a time from execute. For each instruction it drives the writeback source select (ALU / memory / link), the register write enable and the destination address. It waits on the data memory for loads, with a bounded timeout, and supports pipeline flush. Sits between execute/decode control and the writeback source mux plus register file.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT without mem_ready before aborting (>=1)
CNT_W, 5, width of wait counter; must hold MEM_TIMEOUT-1
LINK_REG, 31, destination register for branch-and-link
ZERO_REG_RO, 1, when 1 writes to register 0 are suppressed (cycle still completes)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
issue_valid  input  1  execute presents an instruction for writeback
issue_kind  input  2  00 ALU, 01 load, 10 branch-and-link, 11 no writeback (store/branch)
issue_rd  input  5  destination register (ignored for kinds 10, 11)
issue_ready  output  1  sequencer can accept an issue this cycle
mem_ready  input  1  load data valid on memory output this cycle
flush  input  1  abort current/pending writeback
err_clr  input  1  clear sticky timeout error
write_control  output  2  select to writeback source mux: 00 ALU, 01 memory, 10 link
reg_write_en  output  1  register file write strobe
reg_write_addr  output  5  register file write address
done  output  1  one-cycle pulse: instruction retired or aborted
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky: a load timed out

Behaviour:
- Reset (async, while rst high): state IDLE; write_control=00, reg_write_en=0, reg_write_addr=0, done=0, busy=0, timeout_err=0, wait counter=0. issue_ready=0 while rst is high.
- States: IDLE, WB, MEM_WAIT, NOWB.
- IDLE:
  - issue_ready=1.
  - Handshake = issue_valid & issue_ready & ~flush. flush in IDLE drops the issue and no state changes.
  - On handshake, capture kind and address (issue_rd, or LINK_REG for kind 10), then go to:
    - kind 00 -> WB, write_control=00
    - kind 10 -> WB, write_control=10
    - kind 01 -> MEM_WAIT, write_control=01, counter=0
    - kind 11 -> NOWB
  - write_control and reg_write_addr are registered at the handshake and held until the next handshake.
- WB: reg_write_en=1 for exactly one cycle and done=1, then IDLE. ALU and link instructions therefore retire 1 cycle after issue; throughput is 1 instruction per 2 cycles.
- MEM_WAIT:
  - If mem_ready=1: reg_write_en=1 and done=1 in that same cycle (combinational from state and mem_ready), then IDLE.
  - Else the counter increments.
  - If the counter equals MEM_TIMEOUT-1 and mem_ready=0: timeout_err<=1, done=1, no write, then IDLE.
  - mem_ready takes priority over timeout in the same cycle.
- NOWB: done=1, no write, then IDLE.
- Write suppression:
  - If ZERO_REG_RO=1 and the captured address is 0, reg_write_en stays 0; done still pulses.
  - Link writes to LINK_REG are never suppressed unless LINK_REG=0.
- flush:
  - In WB or MEM_WAIT, flush forces reg_write_en=0, done=1 and a return to IDLE.
  - flush has priority over mem_ready and over timeout. A flush-aborted load does not set timeout_err.
  - In NOWB, done still pulses.
- timeout_err:
  - Set by a timeout; cleared by err_clr.
  - A set in the same cycle as err_clr wins (the bit stays 1).
- busy = (state != IDLE). reg_write_en is never high in IDLE.
- rst asserted mid-operation: immediate return to IDLE with reset output values; the in-flight write is lost.

Test Plan:
1. ALU issue, rd=7 at cycle 0 -> cycle 1: write_control=00, reg_write_en=1, addr=7, done=1; issue_ready=0 in cycle 1, 1 in cycle 2.
2. Load, rd=3; mem_ready low 4 cycles, then high -> reg_write_en=1 and write_control=01 only in the mem_ready cycle; addr=3; busy high throughout.
3. Load with mem_ready never high, MEM_TIMEOUT=16 -> exactly 16 MEM_WAIT cycles, then done=1 with no write; timeout_err=1 until err_clr, which clears it the next cycle.
4. Branch-and-link with issue_rd=5 -> addr=31, write_control=10, one write; ALU issue with rd=0 -> done=1, reg_write_en=0.
5. flush asserted in the same cycle as mem_ready during MEM_WAIT -> no write, done=1, timeout_err unchanged; issue_valid with flush in IDLE -> ignored, busy stays 0.
6. rst pulsed during MEM_WAIT -> all outputs immediately at reset values; a subsequent ALU issue completes normally.

Source files
------------

// File: rtl/wb_sequencer_if.sv
// Writeback sequencer bundle: issue handshake, memory status,
// flush/error control and the register-file write port.
interface wb_sequencer_if;
    logic       issue_valid;
    logic [1:0] issue_kind;
    logic [4:0] issue_rd;
    logic       issue_ready;
    logic       mem_ready;
    logic       flush;
    logic       err_clr;
    logic [1:0] write_control;
    logic       reg_write_en;
    logic [4:0] reg_write_addr;
    logic       done;
    logic       busy;
    logic       timeout_err;

    modport master (
        output issue_valid, issue_kind, issue_rd,
        output mem_ready, flush, err_clr,
        input  issue_ready, write_control,
        input  reg_write_en, reg_write_addr,
        input  done, busy, timeout_err
    );

    modport slave (
        input  issue_valid, issue_kind, issue_rd,
        input  mem_ready, flush, err_clr,
        output issue_ready, write_control,
        output reg_write_en, reg_write_addr,
        output done, busy, timeout_err
    );
endinterface

// File: rtl/wb_sequencer.sv
// Writeback-stage sequencer: one instruction in flight, drives the
// writeback mux select and register-file write strobe.
module wb_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5,
    parameter logic [4:0]  LINK_REG    = 5'd31,
    parameter bit          ZERO_REG_RO = 1'b1
) (
    input logic           clk,
    input logic           rst,
    wb_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        MEM_WAIT,
        NOWB
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q;
    logic [1:0]       wc_q;
    logic [4:0]       addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             terr_q;

    logic hs;
    logic suppress;
    logic cnt_last;
    logic terr_set;
    logic we;
    logic dn;

    assign hs       = bus.issue_valid & bus.issue_ready & ~bus.flush;
    assign suppress = ZERO_REG_RO && (addr_q == 5'd0);
    assign cnt_last = (cnt_q == CNT_LAST);
    // flush and mem_ready both pre-empt the timeout
    assign terr_set = (state_q == MEM_WAIT) & ~bus.flush
                    & ~bus.mem_ready & cnt_last;

    always_comb begin
        we = 1'b0;
        dn = 1'b0;
        unique case (state_q)
            IDLE: begin
                we = 1'b0;
                dn = 1'b0;
            end
            WB: begin
                we = ~bus.flush & ~suppress;
                dn = 1'b1;
            end
            MEM_WAIT: begin
                we = bus.mem_ready & ~bus.flush & ~suppress;
                dn = bus.flush | bus.mem_ready | cnt_last;
            end
            NOWB: begin
                we = 1'b0;
                dn = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wc_q    <= 2'b00;
            addr_q  <= 5'd0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            if (terr_set) begin
                terr_q <= 1'b1;
            end else if (bus.err_clr) begin
                terr_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (hs) begin
                        addr_q <= (bus.issue_kind == 2'b10) ?
                                  LINK_REG : bus.issue_rd;
                        unique case (bus.issue_kind)
                            2'b00: begin
                                state_q <= WB;
                                wc_q    <= 2'b00;
                            end
                            2'b01: begin
                                state_q <= MEM_WAIT;
                                wc_q    <= 2'b01;
                                cnt_q   <= '0;
                            end
                            2'b10: begin
                                state_q <= WB;
                                wc_q    <= 2'b10;
                            end
                            2'b11: begin
                                state_q <= NOWB;
                            end
                        endcase
                    end
                end
                WB, NOWB: begin
                    state_q <= IDLE;
                end
                MEM_WAIT: begin
                    if (bus.flush || bus.mem_ready || cnt_last) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.issue_ready    = (state_q == IDLE) & ~rst;
    assign bus.write_control  = wc_q;
    assign bus.reg_write_en   = we;
    assign bus.reg_write_addr = addr_q;
    assign bus.done           = dn;
    assign bus.busy           = (state_q != IDLE);
    assign bus.timeout_err    = terr_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: a vector table for single
// instructions plus hand-written timeout, flush and reset sequences.
module tb_wb_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_sequencer_if bus ();

    wb_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;
        logic [4:0] rd;
        int         lat;
        logic [1:0] wc;
        logic       we;
        logic [4:0] addr;
        bit         chk_wc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] kind, input logic [4:0] rd);
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_kind  = kind;
        bus.issue_rd    = rd;
        #1;
        chk("issue_ready_idle", bus.issue_ready, 1);
        @(negedge clk);
        bus.issue_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        issue(v.kind, v.rd);
        if (v.kind == 2'b01) begin
            for (int i = 0; i < v.lat; i++) begin
                #1;
                chk($sformatf("v%0d_wait_we", n), bus.reg_write_en, 0);
                chk($sformatf("v%0d_wait_done", n), bus.done, 0);
                chk($sformatf("v%0d_wait_busy", n), bus.busy, 1);
                @(negedge clk);
            end
            bus.mem_ready = 1'b1;
        end
        #1;
        chk($sformatf("v%0d_we", n), bus.reg_write_en, v.we);
        chk($sformatf("v%0d_done", n), bus.done, 1);
        chk($sformatf("v%0d_busy", n), bus.busy, 1);
        chk($sformatf("v%0d_rdy_lo", n), bus.issue_ready, 0);
        if (v.chk_wc) begin
            chk($sformatf("v%0d_wc", n), bus.write_control, v.wc);
            chk($sformatf("v%0d_addr", n), bus.reg_write_addr, v.addr);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk($sformatf("v%0d_rdy_hi", n), bus.issue_ready, 1);
        chk($sformatf("v%0d_idle_busy", n), bus.busy, 0);
        chk($sformatf("v%0d_idle_done", n), bus.done, 0);
        chk($sformatf("v%0d_idle_we", n), bus.reg_write_en, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{2'b00, 5'd7,  0, 2'b00, 1'b1, 5'd7,  1'b1};
        vecs[1] = '{2'b01, 5'd3,  4, 2'b01, 1'b1, 5'd3,  1'b1};
        vecs[2] = '{2'b10, 5'd5,  0, 2'b10, 1'b1, 5'd31, 1'b1};
        vecs[3] = '{2'b00, 5'd0,  0, 2'b00, 1'b0, 5'd0,  1'b1};
        vecs[4] = '{2'b11, 5'd9,  0, 2'b00, 1'b0, 5'd0,  1'b0};
        vecs[5] = '{2'b01, 5'd0,  0, 2'b01, 1'b0, 5'd0,  1'b1};
        vecs[6] = '{2'b01, 5'd12, 0, 2'b01, 1'b1, 5'd12, 1'b1};

        rst             = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_kind  = 2'b00;
        bus.issue_rd    = 5'd0;
        bus.mem_ready   = 1'b0;
        bus.flush       = 1'b0;
        bus.err_clr     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", bus.issue_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.reg_write_en, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wc", bus.write_control, 0);
        chk("rst_addr", bus.reg_write_addr, 0);
        chk("rst_terr", bus.timeout_err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // timeout: 16 MEM_WAIT cycles, err_clr in the setting cycle loses
        issue(2'b01, 5'd4);
        for (int c = 1; c < 16; c++) begin
            #1;
            chk($sformatf("to_c%0d_done", c), bus.done, 0);
            chk($sformatf("to_c%0d_we", c), bus.reg_write_en, 0);
            chk($sformatf("to_c%0d_busy", c), bus.busy, 1);
            @(negedge clk);
        end
        bus.err_clr = 1'b1;
        #1;
        chk("to_last_done", bus.done, 1);
        chk("to_last_we", bus.reg_write_en, 0);
        chk("to_last_terr", bus.timeout_err, 0);
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1;
        chk("to_terr_set", bus.timeout_err, 1);
        chk("to_idle_busy", bus.busy, 0);
        bus.err_clr = 1'b1;
        #1;
        chk("clr_same_cycle", bus.timeout_err, 1);
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1;
        chk("clr_next_cycle", bus.timeout_err, 0);

        // flush with mem_ready in MEM_WAIT
        issue(2'b01, 5'd10);
        #1;
        chk("fl_mem_busy", bus.busy, 1);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.flush     = 1'b1;
        #1;
        chk("fl_mem_we", bus.reg_write_en, 0);
        chk("fl_mem_done", bus.done, 1);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.flush     = 1'b0;
        #1;
        chk("fl_mem_idle", bus.busy, 0);
        chk("fl_mem_terr", bus.timeout_err, 0);

        // flush in WB
        issue(2'b00, 5'd8);
        bus.flush = 1'b1;
        #1;
        chk("fl_wb_we", bus.reg_write_en, 0);
        chk("fl_wb_done", bus.done, 1);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("fl_wb_idle", bus.busy, 0);

        // flush in IDLE drops the issue
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_kind  = 2'b00;
        bus.issue_rd    = 5'd14;
        bus.flush       = 1'b1;
        #1;
        chk("fl_idle_done", bus.done, 0);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b0;
        #1;
        chk("fl_idle_busy", bus.busy, 0);
        chk("fl_idle_done2", bus.done, 0);
        chk("fl_idle_addr", bus.reg_write_addr, 5'd8);

        // reset during MEM_WAIT
        issue(2'b01, 5'd6);
        #1;
        chk("mr_busy", bus.busy, 1);
        chk("mr_wc", bus.write_control, 2'b01);
        @(negedge clk);
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        chk("mr_ready", bus.issue_ready, 0);
        chk("mr_busy0", bus.busy, 0);
        chk("mr_we", bus.reg_write_en, 0);
        chk("mr_done", bus.done, 0);
        chk("mr_wc0", bus.write_control, 0);
        chk("mr_addr0", bus.reg_write_addr, 0);
        @(negedge clk);
        rst           = 1'b0;
        bus.mem_ready = 1'b0;
        run_vec('{2'b00, 5'd9, 0, 2'b00, 1'b1, 5'd9, 1'b1}, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
